// File: rtl/register_serializer.sv
// Parallel-to-serial shifter: captures d on load&&ready, emits WIDTH bits on sout, then a one-cycle done.
// Outputs are decoded from state registers only; a load while busy is dropped, the requester must hold it.
module register_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [WIDTH-1:0]         d,
   output logic                     ready,
   output logic                     sout,
   output logic                     valid,
   output logic                     done,
   output logic                     parity,
   output logic [$clog2(WIDTH)-1:0] bit_idx
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             parity_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         shreg  <= '0;
         cnt    <= '0;
         parity <= 1'b0;
      end else begin
         state  <= state_nxt;
         shreg  <= shreg_nxt;
         cnt    <= cnt_nxt;
         parity <= parity_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      cnt_nxt    = cnt;
      parity_nxt = parity;
      ready      = 1'b0;
      valid      = 1'b0;
      done       = 1'b0;
      sout       = 1'b0;
      bit_idx    = cnt;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (load) begin
               shreg_nxt  = d;
               parity_nxt = ^d;
               cnt_nxt    = '0;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            valid = 1'b1;
            // Shift toward whichever end feeds sout, zero-filling behind.
            if (MSB_FIRST) begin
               sout      = shreg[WIDTH-1];
               shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            end else begin
               sout      = shreg[0];
               shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
            end
            if (cnt == CW'(WIDTH-1)) begin
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_register_serializer.sv
// Bench for register_serializer: MSB-first and LSB-first instances share stimulus; a timeline model
// predicts accepted frames and a negedge monitor pops expected bits and done pulses from queues.
module tb_register_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load;
   logic [W-1:0] d;

   logic         m_ready, m_sout, m_valid, m_done, m_parity;
   logic [2:0]   m_idx;
   logic         l_ready, l_sout, l_valid, l_done, l_parity;
   logic [2:0]   l_idx;

   register_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk(clk), .rst_n(rst_n), .load(load), .d(d),
      .ready(m_ready), .sout(m_sout), .valid(m_valid), .done(m_done),
      .parity(m_parity), .bit_idx(m_idx)
   );

   register_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk(clk), .rst_n(rst_n), .load(load), .d(d),
      .ready(l_ready), .sout(l_sout), .valid(l_valid), .done(l_done),
      .parity(l_parity), .bit_idx(l_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   e;
      logic bm;
      logic bl;
      int   idx;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   edge_n     = 0;
   int   next_ok    = 0;
   logic exp_ready  = 1'b1;
   logic exp_parity = 1'b0;
   int   done_seen  = 0;
   int   checks     = 0;
   int   errors     = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_n, act, req);
      end
   endtask

   // Reference timeline: an accepted load at edge k owns edges k..k+W-1 for data,
   // k+W for done, and the next load can be taken at edge k+W+2.
   always @(posedge clk) begin
      edge_n++;
      if (rst_n === 1'b1 && load === 1'b1 && edge_n >= next_ok) begin
         for (int i = 0; i < W; i++) begin
            exp_t e;
            e.e   = edge_n + i;
            e.bm  = d[W-1-i];
            e.bl  = d[i];
            e.idx = i;
            exp_q.push_back(e);
         end
         done_q.push_back(edge_n + W);
         next_ok    = edge_n + W + 2;
         exp_parity = ^d;
      end
      exp_ready = (edge_n + 1 >= next_ok);
   end

   always @(negedge rst_n) begin
      exp_q.delete();
      done_q.delete();
      next_ok    = 0;
      exp_ready  = 1'b1;
      exp_parity = 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      logic ev, ed;
      while (exp_q.size() > 0 && exp_q[0].e < edge_n) void'(exp_q.pop_front());
      while (done_q.size() > 0 && done_q[0] < edge_n) void'(done_q.pop_front());
      ev = (exp_q.size() > 0 && exp_q[0].e == edge_n);
      ed = (done_q.size() > 0 && done_q[0] == edge_n);
      e  = '{e: 0, bm: 1'b0, bl: 1'b0, idx: 0};
      if (ev) e = exp_q.pop_front();
      if (ed) void'(done_q.pop_front());
      if (m_done === 1'b1) done_seen++;
      chk("valid_msb",  m_valid,  ev);
      chk("valid_lsb",  l_valid,  ev);
      chk("sout_msb",   m_sout,   e.bm);
      chk("sout_lsb",   l_sout,   e.bl);
      chk("bitidx_msb", m_idx,    e.idx);
      chk("bitidx_lsb", l_idx,    e.idx);
      chk("done_msb",   m_done,   ed);
      chk("done_lsb",   l_done,   ed);
      chk("ready_msb",  m_ready,  exp_ready);
      chk("ready_lsb",  l_ready,  exp_ready);
      chk("parity_msb", m_parity, exp_parity);
      chk("parity_lsb", l_parity, exp_parity);
   end

   // Inputs change 2 time units after a rising edge and are held for n edges.
   task automatic drive(input logic l, input logic [W-1:0] dd, input int n);
      load = l;
      d    = dd;
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      load  = 1'b1;
      d     = 8'hFF;
      repeat (3) @(posedge clk);
      #2;
      load  = 1'b0;
      rst_n = 1'b1;
      drive(1'b0, 8'h00, 2);

      drive(1'b1, 8'b11010110, 1);
      drive(1'b0, 8'h00, 12);
      drive(1'b1, 8'b10011100, 1);
      drive(1'b0, 8'h00, 12);
      drive(1'b1, 8'h00, 1);
      drive(1'b0, 8'h00, 12);

      // Load pulse while busy must be ignored.
      drive(1'b1, 8'hA5, 1);
      drive(1'b0, 8'h00, 3);
      drive(1'b1, 8'h3C, 1);
      drive(1'b0, 8'h00, 10);

      base = done_seen;
      drive(1'b1, 8'h81, 30);
      drive(1'b0, 8'h00, 3);
      chk("continuous_done_count", done_seen - base, 3);

      // Reset in the middle of a frame aborts it asynchronously.
      drive(1'b1, 8'hF0, 1);
      drive(1'b0, 8'h00, 4);
      base = done_seen;
      #1 rst_n = 1'b0;
      #1;
      chk("async_valid_msb", m_valid, 1'b0);
      chk("async_valid_lsb", l_valid, 1'b0);
      chk("async_ready_msb", m_ready, 1'b1);
      chk("async_sout_msb",  m_sout,  1'b0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1'b0, 8'h00, 3);
      chk("abort_no_done", done_seen - base, 0);
      drive(1'b1, 8'h0F, 1);
      drive(1'b0, 8'h00, 12);

      repeat (400) drive($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(1, 3));
      drive(1'b1, W'($urandom), 25);
      drive(1'b0, 8'h00, 14);

      chk("exp_queue_drained",  exp_q.size(),  0);
      chk("done_queue_drained", done_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
